// File: rtl/uart_fb_loader.sv
// Framed UART-to-framebuffer loader: parses SYNC/CMD packets and unpacks pixels into RAM writes.
// Optional double buffering is enabled with the UART_FB_LOADER_DBUF_EN macro.
module uart_fb_loader #(
   parameter int unsigned PIX_W       = 4,
   parameter int unsigned FB_W        = 640,
   parameter int unsigned FB_H        = 480,
   parameter int unsigned ADDR_W      = 19,
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
   parameter int unsigned TIMEOUT_CYC = 200000
) (
   input  logic              clk_sys,
   input  logic              rst_n,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              fb_wr,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [PIX_W-1:0]  fb_data,
   output logic              busy,
   output logic              frame_done,
   output logic              err_ovf,
   output logic              err_cmd,
`ifdef UART_FB_LOADER_DBUF_EN
   output logic              fb_bank,
   output logic              wr_bank,
`endif
   output logic              err_tmo
);

   localparam int unsigned PPB    = 8 / PIX_W;
   localparam int unsigned N_PIX  = FB_W * FB_H;
   localparam int unsigned CNT_W  = ($clog2(N_PIX + 1) > 17) ? $clog2(N_PIX + 1) : 17;
   localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned SLOT_W = 4;

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_CMD    = 4'd1;
   localparam logic [3:0] S_ADDR0  = 4'd2;
   localparam logic [3:0] S_ADDR1  = 4'd3;
   localparam logic [3:0] S_ADDR2  = 4'd4;
   localparam logic [3:0] S_LEN0   = 4'd5;
   localparam logic [3:0] S_LEN1   = 4'd6;
   localparam logic [3:0] S_PIX    = 4'd7;
   localparam logic [3:0] S_UNPACK = 4'd8;

   logic [3:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  remain_q, remain_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [7:0]        shift_q, shift_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [23:0]       addr_acc_q, addr_acc_d;
   logic [7:0]        len_hi_q, len_hi_d;

   logic              fb_wr_d, busy_d, frame_done_d;
   logic [ADDR_W-1:0] fb_addr_d;
   logic [PIX_W-1:0]  fb_data_d;
   logic              err_ovf_d, err_cmd_d, err_tmo_d;

   logic              emit;
   logic [PIX_W-1:0]  emit_pix;
   logic              tmo_hit;
   logic [24:0]       region_last;
   logic              region_oob;

`ifdef UART_FB_LOADER_DBUF_EN
   logic full_q, full_d;
   logic fb_bank_d, wr_bank_d;
`endif

   // Last pixel address of a region request, checked against the frame size
   assign region_last = {1'b0, addr_acc_q} + {9'd0, len_hi_q, rx_data};
   assign region_oob  = region_last > 25'(N_PIX - 1);
   assign tmo_hit     = !rx_valid && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      remain_d     = remain_q;
      slot_d       = slot_q;
      shift_d      = shift_q;
      tmo_d        = '0;
      addr_acc_d   = addr_acc_q;
      len_hi_d     = len_hi_q;
      fb_wr_d      = 1'b0;
      frame_done_d = 1'b0;
      fb_addr_d    = fb_addr;
      fb_data_d    = fb_data;
      err_ovf_d    = err_ovf;
      err_cmd_d    = err_cmd;
      err_tmo_d    = err_tmo;
      emit         = 1'b0;
      emit_pix     = '0;
`ifdef UART_FB_LOADER_DBUF_EN
      full_d       = full_q;
`endif

      if (state_q != S_IDLE) begin
         tmo_d = rx_valid ? '0 : tmo_q + TMO_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
               state_d   = S_CMD;
               err_ovf_d = 1'b0;
               err_cmd_d = 1'b0;
               err_tmo_d = 1'b0;
            end
         end
         S_CMD: begin
            if (rx_valid) begin
               if (rx_data == 8'h01) begin
                  state_d  = S_PIX;
                  addr_d   = '0;
                  remain_d = CNT_W'(N_PIX);
`ifdef UART_FB_LOADER_DBUF_EN
                  full_d   = 1'b1;
`endif
               end else if (rx_data == 8'h02) begin
                  state_d  = S_ADDR0;
`ifdef UART_FB_LOADER_DBUF_EN
                  full_d   = 1'b0;
`endif
               end else begin
                  state_d   = S_IDLE;
                  err_cmd_d = 1'b1;
               end
            end
         end
         S_ADDR0: begin
            if (rx_valid) begin
               addr_acc_d[23:16] = rx_data;
               state_d           = S_ADDR1;
            end
         end
         S_ADDR1: begin
            if (rx_valid) begin
               addr_acc_d[15:8] = rx_data;
               state_d          = S_ADDR2;
            end
         end
         S_ADDR2: begin
            if (rx_valid) begin
               addr_acc_d[7:0] = rx_data;
               state_d         = S_LEN0;
            end
         end
         S_LEN0: begin
            if (rx_valid) begin
               len_hi_d = rx_data;
               state_d  = S_LEN1;
            end
         end
         S_LEN1: begin
            if (rx_valid) begin
               if (region_oob) begin
                  state_d   = S_IDLE;
                  err_cmd_d = 1'b1;
               end else begin
                  state_d  = S_PIX;
                  addr_d   = ADDR_W'(addr_acc_q);
                  remain_d = CNT_W'({len_hi_q, rx_data}) + CNT_W'(1);
               end
            end
         end
         S_PIX: begin
            // First pixel of the byte is written straight from the receive strobe
            if (rx_valid) begin
               emit     = 1'b1;
               emit_pix = rx_data[PIX_W-1:0];
               shift_d  = rx_data >> PIX_W;
               slot_d   = SLOT_W'(PPB - 1);
               state_d  = S_UNPACK;
            end
         end
         S_UNPACK: begin
            if (rx_valid) begin
               err_ovf_d = 1'b1;
            end
            if (remain_q == '0) begin
               state_d = S_IDLE;
            end else if (slot_q == '0) begin
               state_d = S_PIX;
            end else begin
               emit     = 1'b1;
               emit_pix = shift_q[PIX_W-1:0];
               shift_d  = shift_q >> PIX_W;
               slot_d   = slot_q - SLOT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (emit) begin
         fb_wr_d      = 1'b1;
         fb_addr_d    = addr_q;
         fb_data_d    = emit_pix;
         addr_d       = addr_q + ADDR_W'(1);
         remain_d     = remain_q - CNT_W'(1);
         frame_done_d = (remain_q == CNT_W'(1));
      end

      // Inter-byte silence aborts the packet; a write in flight is dropped
      if ((state_q != S_IDLE) && tmo_hit) begin
         state_d      = S_IDLE;
         err_tmo_d    = 1'b1;
         fb_wr_d      = 1'b0;
         frame_done_d = 1'b0;
      end

      busy_d = (state_d != S_IDLE);
   end

`ifdef UART_FB_LOADER_DBUF_EN
   // Bank swaps once the last write of a full frame has been issued
   always_comb begin
      fb_bank_d = fb_bank ^ (frame_done & full_q);
      wr_bank_d = ~fb_bank_d;
   end
`endif

   // State and output registers
   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         remain_q   <= '0;
         slot_q     <= '0;
         shift_q    <= '0;
         tmo_q      <= '0;
         addr_acc_q <= '0;
         len_hi_q   <= '0;
         fb_wr      <= 1'b0;
         fb_addr    <= '0;
         fb_data    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         err_ovf    <= 1'b0;
         err_cmd    <= 1'b0;
         err_tmo    <= 1'b0;
`ifdef UART_FB_LOADER_DBUF_EN
         full_q     <= 1'b0;
         fb_bank    <= 1'b0;
         wr_bank    <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         remain_q   <= remain_d;
         slot_q     <= slot_d;
         shift_q    <= shift_d;
         tmo_q      <= tmo_d;
         addr_acc_q <= addr_acc_d;
         len_hi_q   <= len_hi_d;
         fb_wr      <= fb_wr_d;
         fb_addr    <= fb_addr_d;
         fb_data    <= fb_data_d;
         busy       <= busy_d;
         frame_done <= frame_done_d;
         err_ovf    <= err_ovf_d;
         err_cmd    <= err_cmd_d;
         err_tmo    <= err_tmo_d;
`ifdef UART_FB_LOADER_DBUF_EN
         full_q     <= full_d;
         fb_bank    <= fb_bank_d;
         wr_bank    <= wr_bank_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_fb_loader.sv
// Bench for uart_fb_loader: three instances (4/8/1-bit pixels) checked against a packet-level model.
module tb_uart_fb_loader;

   localparam int unsigned AW  = 19;
   localparam int          GAP = 12;

   typedef logic [7:0] bq_t [$];
   typedef struct { int dut; int addr; int data; bit fd; } wr_t;

   logic          clk_sys = 1'b0;
   logic          rst_n;
   logic          rx_valid [3];
   logic [7:0]    rx_data [3];
   logic          fb_wr [3];
   logic          busy [3];
   logic          frame_done [3];
   logic          err_ovf [3];
   logic          err_cmd [3];
   logic          err_tmo [3];
   logic [AW-1:0] fb_addr [3];
   logic [7:0]    fb_data [3];
   logic [3:0]    fbd_a;
   logic [7:0]    fbd_b;
   logic [0:0]    fbd_c;

   wr_t got[$];
   wr_t exp_q[$];
   bit  exp_err;
   int  total = 0;
   int  bad = 0;

   always #5 clk_sys = ~clk_sys;

   assign fb_data[0] = 8'(fbd_a);
   assign fb_data[1] = fbd_b;
   assign fb_data[2] = 8'(fbd_c);

   uart_fb_loader #(.PIX_W(4), .FB_W(4), .FB_H(2), .ADDR_W(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(50)) u_dut_a (
      .clk_sys(clk_sys), .rst_n(rst_n), .rx_valid(rx_valid[0]), .rx_data(rx_data[0]),
      .fb_wr(fb_wr[0]), .fb_addr(fb_addr[0]), .fb_data(fbd_a), .busy(busy[0]),
      .frame_done(frame_done[0]), .err_ovf(err_ovf[0]), .err_cmd(err_cmd[0]), .err_tmo(err_tmo[0]));

   uart_fb_loader #(.PIX_W(8), .FB_W(4), .FB_H(4), .ADDR_W(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(50)) u_dut_b (
      .clk_sys(clk_sys), .rst_n(rst_n), .rx_valid(rx_valid[1]), .rx_data(rx_data[1]),
      .fb_wr(fb_wr[1]), .fb_addr(fb_addr[1]), .fb_data(fbd_b), .busy(busy[1]),
      .frame_done(frame_done[1]), .err_ovf(err_ovf[1]), .err_cmd(err_cmd[1]), .err_tmo(err_tmo[1]));

   uart_fb_loader #(.PIX_W(1), .FB_W(4), .FB_H(4), .ADDR_W(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(50)) u_dut_c (
      .clk_sys(clk_sys), .rst_n(rst_n), .rx_valid(rx_valid[2]), .rx_data(rx_data[2]),
      .fb_wr(fb_wr[2]), .fb_addr(fb_addr[2]), .fb_data(fbd_c), .busy(busy[2]),
      .frame_done(frame_done[2]), .err_ovf(err_ovf[2]), .err_cmd(err_cmd[2]), .err_tmo(err_tmo[2]));

   // Write monitor; a frame_done without a write is logged with address -1
   always @(negedge clk_sys) begin
      for (int d = 0; d < 3; d++) begin
         if (fb_wr[d] === 1'b1 || frame_done[d] === 1'b1)
            got.push_back('{d, (fb_wr[d] === 1'b1) ? int'(fb_addr[d]) : -1,
                            int'(fb_data[d]), frame_done[d] === 1'b1});
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Caller is always 1 time unit after a rising edge
   task automatic send_byte(input int d, input logic [7:0] b, input int gap);
      rx_data[d]  = b;
      rx_valid[d] = 1'b1;
      tick();
      rx_valid[d] = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic send_pkt(input int d, input bq_t pkt);
      foreach (pkt[i]) send_byte(d, pkt[i], GAP);
   endtask

   // Packet-level model: expected writes for a well-spaced packet on instance d
   task automatic build_expect(input int d, input bq_t pkt);
      int pw, npix, ppb, start, n, p, a, l, bi, pix;
      pw   = (d == 0) ? 4 : (d == 1) ? 8 : 1;
      npix = (d == 0) ? 8 : 16;
      ppb  = 8 / pw;
      exp_q.delete();
      exp_err = 1'b0;
      n = 0; start = 0; p = 0;
      if (pkt[1] == 8'h01) begin
         n = npix; p = 2;
      end else if (pkt[1] == 8'h02) begin
         a = int'({pkt[2], pkt[3], pkt[4]});
         l = int'({pkt[5], pkt[6]});
         if (a + l > npix - 1) exp_err = 1'b1;
         else begin start = a; n = l + 1; p = 7; end
      end else begin
         exp_err = 1'b1;
      end
      for (int i = 0; i < n; i++) begin
         bi = p + i / ppb;
         if (bi >= pkt.size()) break;
         pix = (int'(pkt[bi]) >> ((i % ppb) * pw)) & ((1 << pw) - 1);
         exp_q.push_back('{d, start + i, pix, i == n - 1});
      end
   endtask

   task automatic compare_writes(input string tag);
      check({tag, "_nwr"}, 64'(got.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         check($sformatf("%s_dut%0d", tag, i), 64'(got[i].dut), 64'(exp_q[i].dut));
         check($sformatf("%s_addr%0d", tag, i), 64'(got[i].addr), 64'(exp_q[i].addr));
         check($sformatf("%s_data%0d", tag, i), 64'(got[i].data), 64'(exp_q[i].data));
         check($sformatf("%s_fd%0d", tag, i), 64'(got[i].fd), 64'(exp_q[i].fd));
      end
      got.delete();
   endtask

   initial begin
      bq_t        pkt;
      logic [7:0] b1;
      int         a, l;

      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         rx_valid[d] = 1'b0;
         rx_data[d]  = 8'h00;
      end
      repeat (3) tick();
      for (int d = 0; d < 3; d++) begin
         check($sformatf("rst_fb_wr%0d", d), 64'(fb_wr[d]), 64'(0));
         check($sformatf("rst_busy%0d", d), 64'(busy[d]), 64'(0));
         check($sformatf("rst_fd%0d", d), 64'(frame_done[d]), 64'(0));
         check($sformatf("rst_ovf%0d", d), 64'(err_ovf[d]), 64'(0));
         check($sformatf("rst_cmd%0d", d), 64'(err_cmd[d]), 64'(0));
         check($sformatf("rst_tmo%0d", d), 64'(err_tmo[d]), 64'(0));
         check($sformatf("rst_addr%0d", d), 64'(fb_addr[d]), 64'(0));
      end
      rst_n = 1'b1;
      tick();
      got.delete();

      // Full frame, 4-bit pixels, with first-write latency check
      pkt = '{8'hA5, 8'h01, 8'h10, 8'h32, 8'h54, 8'h76};
      build_expect(0, pkt);
      send_byte(0, 8'hA5, GAP);
      send_byte(0, 8'h01, GAP);
      send_byte(0, 8'h10, 0);
      check("lat_wr", 64'(fb_wr[0]), 64'(1));
      check("lat_addr", 64'(fb_addr[0]), 64'(0));
      check("lat_data", 64'(fb_data[0]), 64'(0));
      repeat (GAP) tick();
      send_byte(0, 8'h32, GAP);
      send_byte(0, 8'h54, GAP);
      send_byte(0, 8'h76, GAP);
      compare_writes("full_a");
      check("full_a_busy", 64'(busy[0]), 64'(0));
      check("full_a_cmd", 64'(err_cmd[0]), 64'(0));

      // Region write, 8-bit pixels
      pkt = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h05, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC};
      build_expect(1, pkt);
      send_pkt(1, pkt);
      compare_writes("region_b");
      check("region_b_cmd", 64'(err_cmd[1]), 64'(0));

      // Region past the last pixel, then SYNC clears, then unknown command
      pkt = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h01};
      build_expect(1, pkt);
      send_pkt(1, pkt);
      compare_writes("oob_b");
      check("oob_b_err", 64'(err_cmd[1]), 64'(exp_err));
      check("oob_b_busy", 64'(busy[1]), 64'(0));
      send_byte(1, 8'hA5, GAP);
      check("oob_b_clear", 64'(err_cmd[1]), 64'(0));
      send_byte(1, 8'h7E, GAP);
      check("badcmd_err", 64'(err_cmd[1]), 64'(1));
      check("badcmd_busy", 64'(busy[1]), 64'(0));
      exp_q.delete();
      send_byte(1, 8'h11, GAP);
      compare_writes("badcmd_nowr");

      // Random region packets
      for (int it = 0; it < 6; it++) begin
         a = int'($urandom_range(0, 15));
         l = int'($urandom_range(0, 5));
         pkt = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'(a), 8'h00, 8'(l)};
         build_expect(1, pkt);
         if (!exp_err) begin
            for (int k = 0; k <= l; k++) pkt.push_back(8'($urandom));
            build_expect(1, pkt);
         end
         send_pkt(1, pkt);
         compare_writes($sformatf("rnd_b%0d", it));
         check($sformatf("rnd_b%0d_err", it), 64'(err_cmd[1]), 64'(exp_err));
         check($sformatf("rnd_b%0d_busy", it), 64'(busy[1]), 64'(0));
      end

      // Random full frames, 4-bit pixels
      for (int it = 0; it < 3; it++) begin
         pkt = '{8'hA5, 8'h01};
         for (int k = 0; k < 4; k++) pkt.push_back(8'($urandom));
         build_expect(0, pkt);
         send_pkt(0, pkt);
         compare_writes($sformatf("rnd_a%0d", it));
         check($sformatf("rnd_a%0d_busy", it), 64'(busy[0]), 64'(0));
      end

      // Overflow: second strobe lands mid-unpack of a 1-bit-pixel byte
      b1  = 8'($urandom);
      pkt = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, b1, 8'h3C};
      build_expect(2, pkt);
      for (int k = 0; k < 7; k++) send_byte(2, pkt[k], GAP);
      send_byte(2, b1, 0);
      repeat (2) tick();
      send_byte(2, ~b1, GAP);
      check("ovf_flag", 64'(err_ovf[2]), 64'(1));
      check("ovf_nwr8", 64'(got.size()), 64'(8));
      send_byte(2, 8'h3C, GAP);
      compare_writes("ovf_c");
      check("ovf_sticky", 64'(err_ovf[2]), 64'(1));
      check("ovf_busy", 64'(busy[2]), 64'(0));

      // Timeout after the command byte
      send_byte(0, 8'hA5, GAP);
      send_byte(0, 8'h01, 0);
      repeat (49) tick();
      check("tmo_busy_pre", 64'(busy[0]), 64'(1));
      check("tmo_flag_pre", 64'(err_tmo[0]), 64'(0));
      tick();
      check("tmo_flag", 64'(err_tmo[0]), 64'(1));
      check("tmo_busy", 64'(busy[0]), 64'(0));
      exp_q.delete();
      compare_writes("tmo_nowr");

      // Reset during unpack cancels the pending write
      send_byte(2, 8'hA5, GAP);
      send_byte(2, 8'h01, GAP);
      send_byte(2, 8'hFF, 0);
      check("rstmid_wr_pre", 64'(fb_wr[2]), 64'(1));
      repeat (2) tick();
      rst_n = 1'b0;
      tick();
      check("rstmid_wr", 64'(fb_wr[2]), 64'(0));
      check("rstmid_busy", 64'(busy[2]), 64'(0));
      check("rstmid_fd", 64'(frame_done[2]), 64'(0));
      check("rstmid_nwr", 64'(got.size()), 64'(3));
      check("rstmid_tmo_a", 64'(err_tmo[0]), 64'(0));
      rst_n = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
